mdu_param: RTL and testbench

Parametrised multiply/divide unit for the execute stage of the pipelined core. It replaces the fixed-width MDU. The unit provides signed and unsigned multiply, divide and multiply-accumulate/subtract into a HI/LO pair, plus direct HI/LO writes. Multiply latency is configurable. Division is a true iterative radix-2 restoring divider. A cancel input lets the hazard or exception logic kill an in-flight operation.

---
 rtl/mdu_param.sv | 168 ++++++++++++++++
 tb/tb_mdu_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_param.sv
// Parametrised multiply/divide unit: multi-cycle multiply and multiply-accumulate into HI/LO,
// iterative radix-2 restoring divide, direct HI/LO writes, and cancel of in-flight work.
module mdu_param #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic             WriteEnabled,
    input  logic             HiLo,
    input  logic             Cancel,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2((WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_dvsr;
    logic             r_busy;
    logic             r_done;

    logic               w_mulSigned;
    logic [2*WIDTH-1:0] w_aExt;
    logic [2*WIDTH-1:0] w_bExt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_mulRes;
    logic               w_isDiv;
    logic               w_divSigned;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic               w_divZero;
    logic               w_negQ;
    logic               w_negR;

    // Sign-extending to 2*WIDTH makes one modulo multiplier serve both signednesses
    assign w_mulSigned = r_op[0];
    assign w_aExt      = {{WIDTH{w_mulSigned & r_a[WIDTH-1]}}, r_a};
    assign w_bExt      = {{WIDTH{w_mulSigned & r_b[WIDTH-1]}}, r_b};
    assign w_prod      = w_aExt * w_bExt;
    assign w_acc       = {r_hi, r_lo};

    always_comb begin
        w_mulRes = w_prod;
        case (r_op[2:1])
            2'b10:   w_mulRes = w_acc + w_prod;
            2'b11:   w_mulRes = w_acc - w_prod;
            default: w_mulRes = w_prod;
        endcase
    end

    assign w_isDiv     = (Op == 3'd2) || (Op == 3'd3);
    assign w_divSigned = (Op == 3'd3);
    assign w_magA      = (w_divSigned && D1[WIDTH-1]) ? -D1 : D1;
    assign w_magB      = (w_divSigned && D2[WIDTH-1]) ? -D2 : D2;

    // One restoring step: the extra top bit of the trial difference is the borrow
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvsr};
    assign w_fits  = ~w_trial[WIDTH];

    assign w_divZero = (r_b == '0);
    assign w_negQ    = r_op[0] & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_negR    = r_op[0] & r_a[WIDTH-1];

    always_ff @(posedge clk) begin
        r_done <= 1'b0;
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_rem   <= '0;
            r_quot  <= '0;
            r_dvsr  <= '0;
            r_busy  <= 1'b0;
        end else if (Cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_op   <= Op;
                        r_a    <= D1;
                        r_b    <= D2;
                        r_rem  <= '0;
                        r_quot <= w_magA;
                        r_dvsr <= w_magB;
                        r_busy <= 1'b1;
                        if (w_isDiv) begin
                            r_state <= S_DIV;
                            r_cnt   <= CW'(WIDTH - 1);
                        end else begin
                            r_state <= S_MUL;
                            r_cnt   <= CW'(MUL_CYCLES - 1);
                        end
                    end else if (WriteEnabled) begin
                        if (HiLo) r_hi <= D1;
                        else      r_lo <= D1;
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        {r_hi, r_lo} <= w_mulRes;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DIV: begin
                    r_rem  <= w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_quot <= {r_quot[WIDTH-2:0], w_fits};
                    if (r_cnt == '0) r_state <= S_FIX;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    // Zero divisor yields all-ones quotient and the raw dividend regardless of sign
                    if (w_divZero) begin
                        r_lo <= {WIDTH{1'b1}};
                        r_hi <= r_a;
                    end else begin
                        r_lo <= w_negQ ? -r_quot : r_quot;
                        r_hi <= w_negR ? -r_rem : r_rem;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_param.sv
// Self-checking bench for mdu_param: expected HI/LO pairs are queued when an op is launched
// and popped when the unit finishes; timing, busy/cancel and reset behaviour checked inline.
module tb_mdu_param;

    localparam int W      = 32;
    localparam int MC     = 5;
    localparam int DIV_BC = W + 1;
    localparam int BOUND  = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  D1, D2;
    logic          Start;
    logic [2:0]    Op;
    logic          WriteEnabled;
    logic          HiLo;
    logic          Cancel;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  HI, LO;

    int            checks = 0;
    int            failures = 0;
    logic [63:0]   expQ[$];
    logic [W-1:0]  mHi, mLo;

    mdu_param #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .D1(D1), .D2(D2), .Start(Start), .Op(Op),
        .WriteEnabled(WriteEnabled), .HiLo(HiLo), .Cancel(Cancel),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Reference behaviour of every op, computed with wide native arithmetic
    function automatic logic [63:0] modelResult(input logic [2:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [63:0] acc);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op[0]) p = sa * sb;
        else       p = {32'b0, a} * {32'b0, b};
        case (op)
            3'd0, 3'd1: return p;
            3'd4, 3'd5: return acc + p;
            3'd6, 3'd7: return acc - p;
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push);
        logic [63:0] e;
        Op = op; D1 = a; D2 = b; Start = 1'b1;
        if (push) begin
            e = modelResult(op, a, b, {mHi, mLo});
            {mHi, mLo} = e;
            expQ.push_back(e);
        end
        step();
        Start = 1'b0;
    endtask

    task automatic waitIdle(output int busyCycles, output logic doneAtEnd);
        busyCycles = 0;
        while (Busy === 1'b1 && busyCycles < BOUND) begin
            busyCycles++;
            step();
        end
        doneAtEnd = Done;
    endtask

    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busyCycles, output logic doneAtEnd);
        launch(op, a, b, 1'b1);
        waitIdle(busyCycles, doneAtEnd);
    endtask

    task automatic writeHiLo(input logic hilo, input logic [31:0] data);
        WriteEnabled = 1'b1; HiLo = hilo; D1 = data;
        step();
        WriteEnabled = 1'b0;
        if (hilo) mHi = data;
        else      mLo = data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++; if (HI !== 32'h0) begin failures++; $display("[TB] FAIL reset_hi got=%h want=0", HI); end
        checks++; if (LO !== 32'h0) begin failures++; $display("[TB] FAIL reset_lo got=%h want=0", LO); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", Done); end
        reset = 1'b0;
        mHi = '0; mLo = '0;
    endtask

    task automatic test_mult();
        int bc; logic dn; logic [63:0] e;
        runOp(3'd1, 32'hFFFF_FFFD, 32'd7, bc, dn);
        e = expQ.pop_front();
        checks++; if (bc != MC) begin failures++; $display("[TB] FAIL mult_busy got=%0d want=%0d", bc, MC); end
        checks++; if (dn !== 1'b1) begin failures++; $display("[TB] FAIL mult_done got=%b want=1", dn); end
        checks++; if (HI !== e[63:32]) begin failures++; $display("[TB] FAIL mult_hi got=%h want=%h", HI, e[63:32]); end
        checks++; if (LO !== e[31:0]) begin failures++; $display("[TB] FAIL mult_lo got=%h want=%h", LO, e[31:0]); end
        step();
        checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL mult_done_pulse got=%b want=0", Done); end
    endtask

    task automatic test_div();
        int bc; logic dn; logic [63:0] e;
        runOp(3'd3, 32'hFFFF_FFF9, 32'd2, bc, dn);
        e = expQ.pop_front();
        checks++; if (bc != DIV_BC) begin failures++; $display("[TB] FAIL div_busy got=%0d want=%0d", bc, DIV_BC); end
        checks++; if (dn !== 1'b1) begin failures++; $display("[TB] FAIL div_done got=%b want=1", dn); end
        checks++; if (LO !== e[31:0]) begin failures++; $display("[TB] FAIL div_lo got=%h want=%h", LO, e[31:0]); end
        checks++; if (HI !== e[63:32]) begin failures++; $display("[TB] FAIL div_hi got=%h want=%h", HI, e[63:32]); end
        runOp(3'd2, 32'hFFFF_FFF9, 32'd2, bc, dn);
        e = expQ.pop_front();
        checks++; if (bc != DIV_BC) begin failures++; $display("[TB] FAIL divu_busy got=%0d want=%0d", bc, DIV_BC); end
        checks++; if (LO !== e[31:0]) begin failures++; $display("[TB] FAIL divu_lo got=%h want=%h", LO, e[31:0]); end
        checks++; if (HI !== e[63:32]) begin failures++; $display("[TB] FAIL divu_hi got=%h want=%h", HI, e[63:32]); end
    endtask

    task automatic test_divzero();
        int bc; logic dn; logic [63:0] e;
        runOp(3'd2, 32'h1234_5678, 32'd0, bc, dn);
        e = expQ.pop_front();
        checks++; if (bc != DIV_BC) begin failures++; $display("[TB] FAIL divu0_busy got=%0d want=%0d", bc, DIV_BC); end
        checks++; if (LO !== e[31:0]) begin failures++; $display("[TB] FAIL divu0_lo got=%h want=%h", LO, e[31:0]); end
        checks++; if (HI !== e[63:32]) begin failures++; $display("[TB] FAIL divu0_hi got=%h want=%h", HI, e[63:32]); end
        runOp(3'd3, 32'h8000_0005, 32'd0, bc, dn);
        e = expQ.pop_front();
        checks++; if (LO !== e[31:0]) begin failures++; $display("[TB] FAIL div0_lo got=%h want=%h", LO, e[31:0]); end
        checks++; if (HI !== e[63:32]) begin failures++; $display("[TB] FAIL div0_hi got=%h want=%h", HI, e[63:32]); end
    endtask

    task automatic test_accum();
        int bc; logic dn; logic [63:0] e;
        writeHiLo(1'b1, 32'h0);
        writeHiLo(1'b0, 32'hFFFF_FFFF);
        checks++; if (LO !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mtlo got=%h want=ffffffff", LO); end
        checks++; if (HI !== 32'h0) begin failures++; $display("[TB] FAIL mthi got=%h want=0", HI); end
        runOp(3'd5, 32'd1, 32'd1, bc, dn);
        e = expQ.pop_front();
        checks++; if (HI !== e[63:32] || LO !== e[31:0]) begin failures++; $display("[TB] FAIL madd got=%h_%h want=%h", HI, LO, e); end
        runOp(3'd6, 32'd1, 32'd1, bc, dn);
        e = expQ.pop_front();
        checks++; if (HI !== e[63:32] || LO !== e[31:0]) begin failures++; $display("[TB] FAIL msubu got=%h_%h want=%h", HI, LO, e); end
    endtask

    task automatic test_busy_ignore();
        int bc; logic dn; logic [63:0] e;
        launch(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        step();
        Start = 1'b1; Op = 3'd1; D1 = 32'd5; D2 = 32'd5; WriteEnabled = 1'b1; HiLo = 1'b1;
        step();
        Start = 1'b0; WriteEnabled = 1'b0;
        checks++; if (HI !== mHi) begin failures++; end
        if (HI !== mHi) $display("[TB] FAIL busy_mthi_hi got=%h want=%h", HI, mHi);
        waitIdle(bc, dn);
        e = expQ.pop_front();
        checks++; if (bc + 2 != DIV_BC) begin failures++; $display("[TB] FAIL busy_ign_len got=%0d want=%0d", bc + 2, DIV_BC); end
        checks++; if (LO !== e[31:0]) begin failures++; $display("[TB] FAIL divmin_lo got=%h want=%h", LO, e[31:0]); end
        checks++; if (HI !== e[63:32]) begin failures++; $display("[TB] FAIL divmin_hi got=%h want=%h", HI, e[63:32]); end
    endtask

    task automatic test_cancel();
        launch(3'd3, 32'd100, 32'd7, 1'b0);
        step(); step();
        Cancel = 1'b1;
        step();
        Cancel = 1'b0;
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL cancel_busy got=%b want=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL cancel_done got=%b want=0", Done); end
        checks++; if (HI !== mHi || LO !== mLo) begin failures++; $display("[TB] FAIL cancel_hilo got=%h_%h want=%h_%h", HI, LO, mHi, mLo); end
        step();
        checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL cancel_late_done got=%b want=0", Done); end
        // Cancel while idle must swallow a simultaneous Start
        Cancel = 1'b1; Start = 1'b1; Op = 3'd0; D1 = 32'd9; D2 = 32'd9;
        step();
        Cancel = 1'b0; Start = 1'b0;
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL cancel_idle_start got=%b want=0", Busy); end
    endtask

    task automatic test_start_beats_write();
        int bc; logic dn; logic [63:0] e; logic [31:0] oldLo;
        oldLo = mLo;
        WriteEnabled = 1'b1; HiLo = 1'b0;
        launch(3'd0, 32'd3, 32'd4, 1'b1);
        WriteEnabled = 1'b0;
        checks++; if (LO !== oldLo) begin failures++; $display("[TB] FAIL start_vs_write_lo got=%h want=%h", LO, oldLo); end
        waitIdle(bc, dn);
        e = expQ.pop_front();
        checks++; if (bc != MC) begin failures++; $display("[TB] FAIL sw_busy got=%0d want=%0d", bc, MC); end
        checks++; if (HI !== e[63:32] || LO !== e[31:0]) begin failures++; $display("[TB] FAIL sw_result got=%h_%h want=%h", HI, LO, e); end
    endtask

    task automatic test_reset_mid();
        int bc; logic dn; logic [63:0] e;
        launch(3'd1, 32'd1234, 32'd5678, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mHi = '0; mLo = '0;
        checks++; if (HI !== 32'h0 || LO !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_hilo got=%h_%h want=0_0", HI, LO); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b want=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_done got=%b want=0", Done); end
        runOp(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dn);
        e = expQ.pop_front();
        checks++; if (bc != MC) begin failures++; $display("[TB] FAIL postrst_busy got=%0d want=%0d", bc, MC); end
        checks++; if (HI !== e[63:32] || LO !== e[31:0]) begin failures++; $display("[TB] FAIL postrst_result got=%h_%h want=%h", HI, LO, e); end
    endtask

    task automatic test_back_to_back();
        int bc, wantBc; logic dn; logic [63:0] e;
        logic [2:0] op; logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
            if (i == 7) begin op = 3'd3; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            wantBc = (op == 3'd2 || op == 3'd3) ? DIV_BC : MC;
            runOp(op, a, b, bc, dn);
            e = expQ.pop_front();
            checks++; if (bc != wantBc || dn !== 1'b1) begin failures++; $display("[TB] FAIL b2b_timing[%0d] op=%0d busy=%0d done=%b want busy=%0d done=1", i, op, bc, dn, wantBc); end
            checks++; if (HI !== e[63:32] || LO !== e[31:0]) begin failures++; $display("[TB] FAIL b2b_result[%0d] op=%0d a=%h b=%h got=%h_%h want=%h", i, op, a, b, HI, LO, e); end
        end
    endtask

    initial begin
        reset = 1'b1; D1 = '0; D2 = '0; Start = 1'b0; Op = '0;
        WriteEnabled = 1'b0; HiLo = 1'b0; Cancel = 1'b0;
        mHi = '0; mLo = '0;
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_accum();
        test_busy_ignore();
        test_cancel();
        test_start_beats_write();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
